// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending/arbitration block.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int IDXW  = 3;

    // IDLE: nothing is presented. PRESENT: an index is held until the consumer accepts it.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

endpackage

// File: rtl/prio_enc_n.sv
// Combinational MSB-first priority encoder: bit N-1 has the highest priority.
module prio_enc_n #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic [N-1:0]    vec_i,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    // Scan upward so the highest set bit is the last one written and wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o = IDXW'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending register with edge/level capture, per-line masking,
// MSB-first arbitration and a valid/ready index handshake.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int N    = N_IRQ,
    parameter int IDXW = irq_pkg::IDXW,
    parameter bit EDGE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    output logic            irq_valid_o,
    output logic [IDXW-1:0] irq_idx_o,
    input  logic            irq_ready_i,
    output logic [N-1:0]    pending_o,
    output logic            overflow_o
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]    req_q;
    logic [N-1:0]    pending_q, pending_d;
    logic            valid_q;
    logic [IDXW-1:0] idx_q;
    logic            ovf_q, ovf_d;
    irq_state_e      state_q;

    logic [N-1:0]    set_vec;
    logic [N-1:0]    clr_vec;
    logic [N-1:0]    cand;
    logic [IDXW-1:0] win_idx;
    logic            win_any;

    // Sources that raise pending bits; the previous-cycle copy of req_i gives the rising edge.
    always_comb begin
        if (EDGE) set_vec = req_i & ~req_q;
        else      set_vec = req_i;
    end

    // Clear only the line being serviced, and only when the handshake completes.
    always_comb begin
        clr_vec = '0;
        if (valid_q && irq_ready_i) clr_vec = ONE << idx_q;
    end

    // New captures override a same-cycle clear; a capture hitting an already-pending bit is lost.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | set_vec;
        ovf_d     = |(set_vec & pending_q & ~clr_vec);
    end

    // Arbitration looks only at the registered pending vector, so a fresh capture waits a cycle.
    assign cand = pending_q & ~mask_i;

    prio_enc_n #(
        .N    (N),
        .IDXW (IDXW)
    ) u_prio_enc (
        .vec_i (cand),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // Request history, pending bits and the overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            req_q     <= req_i;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // Presentation FSM: latch a winner in IDLE, hold it untouched in PRESENT until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && win_any) begin
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (irq_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_valid_o = valid_q;
    assign irq_idx_o   = idx_q;
    assign pending_o   = pending_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the pending/arbitration rules.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] req_i = '0;
    logic [7:0] mask_i = '0;
    logic       irq_ready_i = 1'b0;
    logic       irq_valid_o;
    logic [2:0] irq_idx_o;
    logic [7:0] pending_o;
    logic       overflow_o;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    irq_pending_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_i       (req_i),
        .mask_i      (mask_i),
        .irq_valid_o (irq_valid_o),
        .irq_idx_o   (irq_idx_o),
        .irq_ready_i (irq_ready_i),
        .pending_o   (pending_o),
        .overflow_o  (overflow_o)
    );

    // Behavioural reference: lines are tracked individually, the winner is found by a downward scan.
    typedef struct packed {
        logic [7:0] pend;
        logic [7:0] prev;
        logic       v;
        logic [2:0] idx;
        logic       ovf;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic [7:0] req, logic [7:0] msk,
                                           logic e, logic rdy);
        mstate_t n;
        int      serviced;
        int      winner;
        serviced = (s.v && rdy) ? int'(s.idx) : -1;
        n        = s;
        n.ovf    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic rising;
            logic keep;
            rising = req[i] && !s.prev[i];
            keep   = s.pend[i] && (i != serviced);
            if (rising && keep) n.ovf = 1'b1;
            n.pend[i] = rising || keep;
        end
        n.prev = req;
        if (s.v) begin
            if (rdy) n.v = 1'b0;
        end else begin
            winner = -1;
            for (int i = 7; i >= 0; i--) begin
                if (winner < 0 && s.pend[i] && !msk[i]) winner = i;
            end
            if (e && winner >= 0) begin
                n.v   = 1'b1;
                n.idx = 3'(winner);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, req_i, mask_i, en, irq_ready_i);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs(int cycles);
        req_i = '0; mask_i = '0; en = 1'b1; irq_ready_i = 1'b0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        ncmp++; if (irq_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", irq_valid_o); end
        ncmp++; if (irq_idx_o !== 3'd0) begin nerr++; $display("FAIL rst_idx: got %0d want 0", irq_idx_o); end
        ncmp++; if (pending_o !== 8'h00) begin nerr++; $display("FAIL rst_pending: got %h want 00", pending_o); end
        ncmp++; if (overflow_o !== 1'b0) begin nerr++; $display("FAIL rst_ovf: got %b want 0", overflow_o); end
        rst_n = 1'b1;
        idle_inputs(2);
    endtask

    task automatic test_single_edge();
        req_i = 8'h08;
        step();
        ncmp++; if (pending_o !== 8'h08) begin nerr++; $display("FAIL se_pend: got %h want 08", pending_o); end
        ncmp++; if (irq_valid_o !== 1'b0) begin nerr++; $display("FAIL se_early_valid: got %b want 0", irq_valid_o); end
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd3) begin nerr++; $display("FAIL se_present: got v=%b idx=%0d want v=1 idx=3", irq_valid_o, irq_idx_o); end
        irq_ready_i = 1'b1;
        step();
        irq_ready_i = 1'b0;
        ncmp++; if (pending_o !== 8'h00 || irq_valid_o !== 1'b0) begin nerr++; $display("FAIL se_accept: got pend=%h v=%b want pend=00 v=0", pending_o, irq_valid_o); end
        idle_inputs(2);
    endtask

    task automatic test_simultaneous();
        req_i = 8'h81;
        step();
        ncmp++; if (pending_o !== 8'h81) begin nerr++; $display("FAIL sim_pend0: got %h want 81", pending_o); end
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd7) begin nerr++; $display("FAIL sim_first: got v=%b idx=%0d want v=1 idx=7", irq_valid_o, irq_idx_o); end
        irq_ready_i = 1'b1;
        step();
        irq_ready_i = 1'b0;
        ncmp++; if (irq_valid_o !== 1'b0 || pending_o !== 8'h01) begin nerr++; $display("FAIL sim_bubble: got v=%b pend=%h want v=0 pend=01", irq_valid_o, pending_o); end
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd0) begin nerr++; $display("FAIL sim_second: got v=%b idx=%0d want v=1 idx=0", irq_valid_o, irq_idx_o); end
        irq_ready_i = 1'b1;
        step();
        irq_ready_i = 1'b0;
        ncmp++; if (pending_o !== 8'h00) begin nerr++; $display("FAIL sim_pend_end: got %h want 00", pending_o); end
        idle_inputs(2);
    endtask

    task automatic test_preempt();
        req_i = 8'h04;
        step();
        step();
        req_i = 8'h44;
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd2 || pending_o !== 8'h44) begin nerr++; $display("FAIL pre_hold: got v=%b idx=%0d pend=%h want v=1 idx=2 pend=44", irq_valid_o, irq_idx_o, pending_o); end
        step();
        ncmp++; if (irq_idx_o !== 3'd2) begin nerr++; $display("FAIL pre_hold2: got idx=%0d want 2", irq_idx_o); end
        irq_ready_i = 1'b1;
        step();
        irq_ready_i = 1'b0;
        ncmp++; if (irq_valid_o !== 1'b0) begin nerr++; $display("FAIL pre_bubble: got v=%b want 0", irq_valid_o); end
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd6) begin nerr++; $display("FAIL pre_next: got v=%b idx=%0d want v=1 idx=6", irq_valid_o, irq_idx_o); end
        irq_ready_i = 1'b1;
        step();
        idle_inputs(2);
    endtask

    task automatic test_mask_en();
        mask_i = 8'h10;
        req_i  = 8'h10;
        step();
        step();
        ncmp++; if (pending_o !== 8'h10 || irq_valid_o !== 1'b0) begin nerr++; $display("FAIL mask_hold: got pend=%h v=%b want pend=10 v=0", pending_o, irq_valid_o); end
        mask_i = 8'h00;
        en     = 1'b0;
        step();
        step();
        ncmp++; if (irq_valid_o !== 1'b0) begin nerr++; $display("FAIL en_low: got v=%b want 0", irq_valid_o); end
        en = 1'b1;
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd4) begin nerr++; $display("FAIL en_high: got v=%b idx=%0d want v=1 idx=4", irq_valid_o, irq_idx_o); end
        irq_ready_i = 1'b1;
        step();
        idle_inputs(2);
    endtask

    task automatic test_overflow();
        req_i = 8'h20;
        step();
        step();
        req_i = 8'h00;
        step();
        req_i = 8'h20;
        step();
        ncmp++; if (overflow_o !== 1'b1 || pending_o !== 8'h20) begin nerr++; $display("FAIL ovf_pulse: got ovf=%b pend=%h want ovf=1 pend=20", overflow_o, pending_o); end
        step();
        ncmp++; if (overflow_o !== 1'b0) begin nerr++; $display("FAIL ovf_single: got %b want 0", overflow_o); end
        req_i = 8'h00;
        step();
        req_i = 8'h20;
        irq_ready_i = 1'b1;
        step();
        irq_ready_i = 1'b0;
        ncmp++; if (pending_o !== 8'h20 || overflow_o !== 1'b0 || irq_valid_o !== 1'b0) begin nerr++; $display("FAIL setclr: got pend=%h ovf=%b v=%b want pend=20 ovf=0 v=0", pending_o, overflow_o, irq_valid_o); end
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd5) begin nerr++; $display("FAIL setclr_re: got v=%b idx=%0d want v=1 idx=5", irq_valid_o, irq_idx_o); end
        req_i = 8'h00;
        irq_ready_i = 1'b1;
        step();
        idle_inputs(2);
    endtask

    task automatic test_async_reset();
        req_i = 8'h08;
        step();
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd3) begin nerr++; $display("FAIL ar_pre: got v=%b idx=%0d want v=1 idx=3", irq_valid_o, irq_idx_o); end
        #2 rst_n = 1'b0;
        #1;
        ncmp++; if (irq_valid_o !== 1'b0 || pending_o !== 8'h00) begin nerr++; $display("FAIL ar_drop: got v=%b pend=%h want v=0 pend=00", irq_valid_o, pending_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ncmp++; if (pending_o !== 8'h08) begin nerr++; $display("FAIL ar_recap: got %h want 08", pending_o); end
        step();
        ncmp++; if (irq_valid_o !== 1'b1 || irq_idx_o !== 3'd3) begin nerr++; $display("FAIL ar_present: got v=%b idx=%0d want v=1 idx=3", irq_valid_o, irq_idx_o); end
        irq_ready_i = 1'b1;
        step();
        idle_inputs(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_i       = 8'($urandom) & 8'($urandom);
            mask_i      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            en          = ($urandom_range(0, 7) != 0);
            irq_ready_i = ($urandom_range(0, 2) == 0);
            step();
            ncmp++; if (pending_o !== m.pend) begin nerr++; $display("FAIL rnd_pend c=%0d: got %h want %h", c, pending_o, m.pend); end
            ncmp++; if (irq_valid_o !== m.v) begin nerr++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, irq_valid_o, m.v); end
            ncmp++; if (irq_idx_o !== m.idx) begin nerr++; $display("FAIL rnd_idx c=%0d: got %0d want %0d", c, irq_idx_o, m.idx); end
            ncmp++; if (overflow_o !== m.ovf) begin nerr++; $display("FAIL rnd_ovf c=%0d: got %b want %b", c, overflow_o, m.ovf); end
        end
        idle_inputs(2);
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_simultaneous();
        test_preempt();
        test_mask_en();
        test_overflow();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
